// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-bus arbiter: access size encoding,
// FSM state encodings and the latched bus request record.
package mem_port_arbiter_pkg;

  typedef logic [1:0] mem_type_bus;

  localparam mem_type_bus MEM_BYTE = 2'd0;
  localparam mem_type_bus MEM_HALF = 2'd1;
  localparam mem_type_bus MEM_WORD = 2'd2;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_REQ_D  = 3'd1,
    ARB_WAIT_D = 3'd2,
    ARB_REQ_I  = 3'd3,
    ARB_WAIT_I = 3'd4,
    ARB_DONE   = 3'd5
  } arb_state_e;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_type_bus typ;
    logic        sign;
  } bus_req_t;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Wait-phase watchdog: clearable counter that flags the cycle it reaches TIMEOUT.
module arb_timeout_cnt #(
  parameter int unsigned TW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TW-1:0] Last   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] MaxCnt = TW'(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT so a very long wait cannot wrap and re-fire.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = en_i && !clr_i && (cnt_q == Last);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory bus between fetch and data access, with
// redirect flush of in-flight fetches, pipeline stall and sticky timeout error.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  mem_type_bus d_type,
  input  logic        d_sign,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output mem_type_bus bus_type,
  output logic        bus_sign,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        err
);

  arb_state_e  state_q, state_d;
  bus_req_t    req_q, req_d;
  bus_req_t    fetch_req, data_req;
  logic        bus_req_q, bus_req_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        discard_q, discard_d;
  logic        err_q;
  logic        cnt_clr, cnt_en, cnt_hit;

  // Fetches are always full-word reads.
  assign fetch_req = '{is_d: 1'b0, we: 1'b0, addr: if_addr, wdata: 32'h0,
                       typ: MEM_WORD, sign: 1'b0};
  assign data_req  = '{is_d: 1'b1, we: d_we, addr: d_addr, wdata: d_wdata,
                       typ: d_type, sign: d_sign};

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    discard_d  = discard_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (d_req) begin
          state_d = ARB_REQ_D;
          req_d   = data_req;
        end else if (if_req) begin
          state_d   = ARB_REQ_I;
          req_d     = fetch_req;
          discard_d = 1'b0;
        end
      end
      ARB_REQ_D: begin
        if (bus_gnt) begin
          state_d = ARB_WAIT_D;
          cnt_clr = 1'b1;
        end
      end
      ARB_REQ_I: begin
        // A grant in the flush cycle is already on the bus: let it finish, discarded.
        if (bus_gnt) begin
          state_d   = ARB_WAIT_I;
          cnt_clr   = 1'b1;
          discard_d = flush;
        end else if (flush) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT_D: begin
        cnt_en = 1'b1;
        if (bus_rvalid) begin
          d_rdata_d = bus_rdata;
          state_d   = ARB_DONE;
        end
      end
      ARB_WAIT_I: begin
        cnt_en = 1'b1;
        if (flush) begin
          discard_d = 1'b1;
        end
        if (bus_rvalid) begin
          if_rdata_d = bus_rdata;
          state_d    = ARB_DONE;
        end
      end
      ARB_DONE: begin
        discard_d = 1'b0;
        if (req_q.is_d && if_req) begin
          state_d = ARB_REQ_I;
          req_d   = fetch_req;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    bus_req_d = (state_d == ARB_REQ_D) || (state_d == ARB_REQ_I);
    if (state_d == ARB_DONE) begin
      d_valid_d  = req_q.is_d;
      if_valid_d = !req_q.is_d && !discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= ARB_IDLE;
      req_q      <= '0;
      bus_req_q  <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      discard_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      bus_req_q  <= bus_req_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      discard_q  <= discard_d;
      err_q      <= err_q | cnt_hit;
    end
  end

  arb_timeout_cnt #(
    .TW     (TW),
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i(clk),
    .rst_i(rstn),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .hit_o(cnt_hit)
  );

  assign bus_req   = bus_req_q;
  assign bus_we    = req_q.we;
  assign bus_addr  = req_q.addr;
  assign bus_wdata = req_q.wdata;
  assign bus_type  = req_q.typ;
  assign bus_sign  = req_q.sign;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

  assign stall = (d_req & ~d_valid_q) | (if_req & ~if_valid_q) |
                 ((state_q != ARB_IDLE) & (state_q != ARB_DONE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// random requesters/memory, all checked every cycle against a transaction model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rstn, flush, if_req, d_req, d_we, d_sign, bus_gnt, bus_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
  mem_type_bus d_type;
  logic [31:0] if_rdata, d_rdata, bus_addr, bus_wdata;
  logic        if_valid, d_valid, bus_req, bus_we, bus_sign, stall, err;
  mem_type_bus bus_type;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // Model: one outstanding transaction described by plain flags.
  logic        m_busy = 0, m_granted = 0, m_resp = 0, m_is_d = 0, m_discard = 0;
  logic        m_we = 0, m_sign = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
  mem_type_bus m_type = '0;
  int          m_wcnt = 0;
  logic        last_dv = 0, last_iv = 0, last_flush = 0;

  logic e_bus_req, e_if_valid, e_d_valid, e_stall;
  assign e_bus_req  = m_busy & ~m_granted;
  assign e_if_valid = m_busy & m_resp & ~m_is_d & ~m_discard;
  assign e_d_valid  = m_busy & m_resp & m_is_d;
  assign e_stall    = (d_req & ~e_d_valid) | (if_req & ~e_if_valid) | (m_busy & ~m_resp);

  mem_port_arbiter #(
    .TIMEOUT(TO),
    .TW     (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_type    (d_type),
    .d_sign    (d_sign),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_type  (bus_type),
    .bus_sign  (bus_sign),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata),
    .stall     (stall),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_req", 32'(bus_req), 32'(e_bus_req));
      chk("bus_we", 32'(bus_we), 32'(m_we));
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("bus_type", 32'(bus_type), 32'(m_type));
      chk("bus_sign", 32'(bus_sign), 32'(m_sign));
      chk("if_valid", 32'(if_valid), 32'(e_if_valid));
      chk("d_valid", 32'(d_valid), 32'(e_d_valid));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
      chk("stall", 32'(stall), 32'(e_stall));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic m_start(input logic is_d);
    m_busy = 1; m_granted = 0; m_resp = 0; m_discard = 0; m_is_d = is_d;
    if (is_d) begin
      m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_type = d_type; m_sign = d_sign;
    end else begin
      m_we = 0; m_addr = if_addr; m_wdata = 0; m_type = MEM_WORD; m_sign = 0;
    end
  endtask

  task automatic model_step();
    logic was_d;
    if (rstn) begin
      m_busy = 0; m_granted = 0; m_resp = 0; m_discard = 0; m_is_d = 0; m_we = 0;
      m_sign = 0; m_err = 0; m_addr = 0; m_wdata = 0; m_type = '0;
      m_if_rdata = 0; m_d_rdata = 0; m_wcnt = 0;
    end else if (!m_busy) begin
      if (d_req) m_start(1'b1);
      else if (if_req) m_start(1'b0);
    end else if (!m_granted) begin
      if (bus_gnt) begin
        m_granted = 1; m_wcnt = 0;
        if (!m_is_d && flush) m_discard = 1;
      end else if (!m_is_d && flush) begin
        m_busy = 0;
      end
    end else if (!m_resp) begin
      m_wcnt++;
      if (m_wcnt == int'(TO)) m_err = 1;
      if (!m_is_d && flush) m_discard = 1;
      if (bus_rvalid) begin
        m_resp = 1;
        if (m_is_d) m_d_rdata = bus_rdata;
        else m_if_rdata = bus_rdata;
      end
    end else begin
      was_d = m_is_d;
      m_busy = 0; m_granted = 0; m_resp = 0; m_discard = 0;
      if (was_d && if_req) m_start(1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    last_dv = e_d_valid; last_iv = e_if_valid; last_flush = flush;
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rstn = 0; flush = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_type = MEM_WORD; d_sign = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  initial begin
    idle_inputs();
    rstn = 1;
    step();
    chk_en = 1;
    step();
    rstn = 0;
    step();

    // Fetch only: if_valid in cycle 3, stall over cycles 0-2.
    for (int c = 0; c <= 4; c++) begin
      case (c)
        0: begin if_req = 1; if_addr = 32'h100; bus_gnt = 1; end
        2: begin bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h13; end
        3: bus_rvalid = 0;
        4: if_req = 0;
        default: ;
      endcase
      @(negedge clk);
      if (c <= 2) chk("t1_stall_hi", 32'(stall), 32'h1);
      if (c == 1) chk("t1_bus_addr", bus_addr, 32'h100);
      if (c == 3) begin
        chk("t1_if_valid", 32'(if_valid), 32'h1);
        chk("t1_if_rdata", if_rdata, 32'h13);
        chk("t1_stall_lo", 32'(stall), 32'h0);
      end
      if (c == 4) chk("t1_pulse", 32'(if_valid), 32'h0);
      step();
    end

    // Simultaneous data load and fetch: data first, fetch right after.
    idle_inputs(); step();
    for (int c = 0; c <= 7; c++) begin
      case (c)
        0: begin
          d_req = 1; d_addr = 32'h2000; if_req = 1; if_addr = 32'h104;
          bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hA5A5_0001;
        end
        4: begin d_req = 0; bus_rdata = 32'h0000_0093; end
        7: if_req = 0;
        default: ;
      endcase
      @(negedge clk);
      if (c <= 5) chk("t2_stall", 32'(stall), 32'h1);
      if (c == 1) chk("t2_addr_d", bus_addr, 32'h2000);
      if (c == 3) begin
        chk("t2_d_valid", 32'(d_valid), 32'h1);
        chk("t2_d_rdata", d_rdata, 32'hA5A5_0001);
      end
      if (c == 4) chk("t2_addr_i", bus_addr, 32'h104);
      if (c == 6) begin
        chk("t2_if_valid", 32'(if_valid), 32'h1);
        chk("t2_if_rdata", if_rdata, 32'h93);
      end
      step();
    end

    // Store with grant held off for four request cycles.
    idle_inputs(); step();
    for (int c = 0; c <= 8; c++) begin
      case (c)
        0: begin d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; end
        5: bus_gnt = 1;
        6: begin bus_gnt = 0; bus_rvalid = 1; end
        7: bus_rvalid = 0;
        8: d_req = 0;
        default: ;
      endcase
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        chk("t3_bus_req", 32'(bus_req), 32'h1);
        chk("t3_bus_addr", bus_addr, 32'h3000);
        chk("t3_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      end
      if (c == 7) chk("t3_d_valid", 32'(d_valid), 32'h1);
      step();
    end

    // Flush during WAIT_I discards the fetch; the next fetch completes.
    idle_inputs(); step();
    for (int c = 0; c <= 9; c++) begin
      case (c)
        0: begin if_req = 1; if_addr = 32'h200; bus_gnt = 1; end
        2: begin bus_gnt = 0; flush = 1; end
        3: begin flush = 0; bus_rvalid = 1; bus_rdata = 32'h1111_1111; if_addr = 32'h300; end
        4: bus_rvalid = 0;
        6: bus_gnt = 1;
        7: begin bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h2222_2222; end
        8: bus_rvalid = 0;
        9: if_req = 0;
        default: ;
      endcase
      @(negedge clk);
      if (c == 4) chk("t4_if_suppressed", 32'(if_valid), 32'h0);
      if (c == 5) chk("t4_idle", 32'(bus_req), 32'h0);
      if (c == 6) chk("t4_addr", bus_addr, 32'h300);
      if (c == 8) begin
        chk("t4_if_valid", 32'(if_valid), 32'h1);
        chk("t4_if_rdata", if_rdata, 32'h2222_2222);
      end
      step();
    end

    // Response late by six wait cycles: err after four, load still completes.
    idle_inputs(); step();
    for (int c = 0; c <= 10; c++) begin
      case (c)
        0: begin d_req = 1; d_addr = 32'h4000; bus_gnt = 1; end
        2: bus_gnt = 0;
        8: begin bus_rvalid = 1; bus_rdata = 32'h5555_AAAA; end
        9: bus_rvalid = 0;
        10: d_req = 0;
        default: ;
      endcase
      @(negedge clk);
      if (c == 5) chk("t5_err_lo", 32'(err), 32'h0);
      if (c == 6) chk("t5_err_hi", 32'(err), 32'h1);
      if (c == 9) begin
        chk("t5_d_valid", 32'(d_valid), 32'h1);
        chk("t5_d_rdata", d_rdata, 32'h5555_AAAA);
      end
      if (c == 10) chk("t5_err_sticky", 32'(err), 32'h1);
      step();
    end

    // Reset in WAIT_D, then a stray response.
    idle_inputs(); step();
    for (int c = 0; c <= 4; c++) begin
      case (c)
        0: begin d_req = 1; d_addr = 32'h5000; bus_gnt = 1; end
        2: begin rstn = 1; d_req = 0; bus_gnt = 0; end
        3: begin rstn = 0; bus_rvalid = 1; bus_rdata = 32'h7777_7777; end
        4: bus_rvalid = 0;
        default: ;
      endcase
      @(negedge clk);
      if (c == 3) begin
        chk("t6_bus_req", 32'(bus_req), 32'h0);
        chk("t6_err", 32'(err), 32'h0);
        chk("t6_stall", 32'(stall), 32'h0);
        chk("t6_bus_addr", bus_addr, 32'h0);
        chk("t6_d_rdata", d_rdata, 32'h0);
      end
      if (c == 4) begin
        chk("t6_no_d_valid", 32'(d_valid), 32'h0);
        chk("t6_still_idle", 32'(bus_req), 32'h0);
      end
      step();
    end

    // Random requesters, memory and flush/reset against the model.
    idle_inputs(); step();
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 299) == 0);
      if (!d_req || last_dv) begin
        d_req   = ($urandom_range(0, 3) == 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_type  = 2'($urandom_range(0, 2));
        d_sign  = 1'($urandom_range(0, 1));
      end
      if (!if_req || last_iv || last_flush) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      flush      = ($urandom_range(0, 11) == 0);
      bus_gnt    = 1'($urandom_range(0, 1));
      bus_rvalid = ($urandom_range(0, 2) == 0);
      bus_rdata  = $urandom;
      step();
    end

    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
